// File: rtl/test_coincidence_counter.sv
// Gated edge/coincidence counter streaming 3-word snapshots over AXI4-Stream.
// Define TEST_COINC_SEQUENCE_EN to append a gate sequence number word.
module test_coincidence_counter #(
  parameter int CNTR_WIDTH = 32,
  parameter int GATE_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [1:0]            test,
  input  logic [GATE_WIDTH-1:0] cfg_gate,
  input  logic                  run,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  overflow
);

  typedef enum logic [2:0] {
    IDLE, SEND0, SEND1, SEND2, SEND3
  } state_t;

  localparam logic [CNTR_WIDTH-1:0] CMAX = '1;

  state_t                  state_q, state_d;
  logic [1:0]              prev_q;
  logic [CNTR_WIDTH-1:0]   cnt0_q, cnt1_q, cntc_q;
  logic [CNTR_WIDTH-1:0]   inc0, inc1, incc;
  logic [CNTR_WIDTH-1:0]   snap0_q, snap1_q, snapc_q;
  logic [GATE_WIDTH-1:0]   timer_q, gate_last;
  logic                    rise0, rise1, risec;
  logic                    gate_end, fire, last_word, load;
  logic                    ovf_q;

  assign rise0 = test[0] & ~prev_q[0];
  assign rise1 = test[1] & ~prev_q[1];
  assign risec = (&test) & ~(&prev_q);

  // Saturating increments; these are also the snapshot values at gate end
  assign inc0 = cnt0_q + CNTR_WIDTH'(rise0 & (cnt0_q != CMAX));
  assign inc1 = cnt1_q + CNTR_WIDTH'(rise1 & (cnt1_q != CMAX));
  assign incc = cntc_q + CNTR_WIDTH'(risec & (cntc_q != CMAX));

  assign gate_last = (cfg_gate == '0) ? '0
                   : cfg_gate - GATE_WIDTH'(1);
  assign gate_end  = run & (timer_q >= gate_last);

  assign m_axis_tvalid = (state_q != IDLE);
  assign fire          = m_axis_tvalid & m_axis_tready;
`ifdef TEST_COINC_SEQUENCE_EN
  assign last_word = (state_q == SEND3);
`else
  assign last_word = (state_q == SEND2);
`endif
  assign load     = gate_end & ((state_q == IDLE) | (last_word & fire));
  assign overflow = ovf_q;

`ifdef TEST_COINC_SEQUENCE_EN
  logic [31:0] seq_q, snaps_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      seq_q   <= '0;
      snaps_q <= '0;
    end else begin
      if (!run)          seq_q <= '0;
      else if (gate_end) seq_q <= seq_q + 32'd1;
      if (load) snaps_q <= seq_q;
    end
  end
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      prev_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      cntc_q  <= '0;
      timer_q <= '0;
      snap0_q <= '0;
      snap1_q <= '0;
      snapc_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= test;
      if (!run || gate_end) begin
        cnt0_q  <= '0;
        cnt1_q  <= '0;
        cntc_q  <= '0;
        timer_q <= '0;
      end else begin
        cnt0_q  <= inc0;
        cnt1_q  <= inc1;
        cntc_q  <= incc;
        timer_q <= timer_q + GATE_WIDTH'(1);
      end
      if (load) begin
        snap0_q <= inc0;
        snap1_q <= inc1;
        snapc_q <= incc;
      end
      if (!run)                 ovf_q <= 1'b0;
      else if (gate_end && !load) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    m_axis_tdata = '0;
    m_axis_tlast = 1'b0;
    unique case (state_q)
      IDLE: if (gate_end) state_d = SEND0;
      SEND0: begin
        m_axis_tdata = 32'(snap0_q);
        if (m_axis_tready) state_d = SEND1;
      end
      SEND1: begin
        m_axis_tdata = 32'(snap1_q);
        if (m_axis_tready) state_d = SEND2;
      end
`ifdef TEST_COINC_SEQUENCE_EN
      SEND2: begin
        m_axis_tdata = 32'(snapc_q);
        if (m_axis_tready) state_d = SEND3;
      end
      SEND3: begin
        m_axis_tdata = snaps_q;
        m_axis_tlast = 1'b1;
        if (m_axis_tready) state_d = gate_end ? SEND0 : IDLE;
      end
`else
      SEND2: begin
        m_axis_tdata = 32'(snapc_q);
        m_axis_tlast = 1'b1;
        if (m_axis_tready) state_d = gate_end ? SEND0 : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_test_coincidence_counter.sv
// Bench for test_coincidence_counter: queue-based stream model plus
// directed packets, run on a 32-bit and a 4-bit counter instance.
module tb_test_coincidence_counter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  test;
  logic [31:0] cfg_gate;
  logic        run;
  logic        tready;

  logic [31:0] tdata_a, tdata_b;
  logic        tvalid_a, tvalid_b;
  logic        tlast_a, tlast_b;
  logic        ovf_a, ovf_b;

  always #5 aclk = ~aclk;

  test_coincidence_counter #(
    .CNTR_WIDTH(32), .GATE_WIDTH(32)
  ) u_dut (
    .aclk(aclk), .aresetn(aresetn), .test(test),
    .cfg_gate(cfg_gate), .run(run),
    .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a),
    .m_axis_tlast(tlast_a), .m_axis_tready(tready),
    .overflow(ovf_a)
  );

  test_coincidence_counter #(
    .CNTR_WIDTH(4), .GATE_WIDTH(32)
  ) u_sat (
    .aclk(aclk), .aresetn(aresetn), .test(test),
    .cfg_gate(cfg_gate), .run(run),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b),
    .m_axis_tlast(tlast_b), .m_axis_tready(tready),
    .overflow(ovf_b)
  );

  int pass_n = 0;
  int total_n = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  // Reference model: words still owed on each stream
  logic [31:0]     qa[$];
  logic [31:0]     qb[$];
  logic [1:0]      m_prev = '0;
  longint unsigned m_c0 = 0, m_c1 = 0, m_cc = 0;
  longint unsigned m_t = 0, m_g;
  logic            m_ovf = 1'b0;
  logic [31:0]     m_seq = '0;
  logic            r0, r1, rc, ge, hs;

  function automatic logic [31:0] sat4(input longint unsigned c);
    return (c > 15) ? 32'd15 : 32'(c);
  endfunction

  always @(posedge aclk) begin
    if (!aresetn) begin
      qa.delete(); qb.delete();
      m_prev = '0; m_c0 = 0; m_c1 = 0; m_cc = 0;
      m_t = 0; m_ovf = 1'b0; m_seq = '0;
    end else begin
      r0 = test[0] && !m_prev[0];
      r1 = test[1] && !m_prev[1];
      rc = (test == 2'b11) && (m_prev != 2'b11);
      m_prev = test;
      hs = (qa.size() != 0) && tready;
      ge = 1'b0;
      if (run) begin
        m_c0 += r0; m_c1 += r1; m_cc += rc;
        m_g = (cfg_gate == 0) ? 1 : cfg_gate;
        ge = (m_t >= m_g - 1);
        m_t = ge ? 0 : m_t + 1;
      end else begin
        m_c0 = 0; m_c1 = 0; m_cc = 0; m_t = 0;
        m_ovf = 1'b0; m_seq = '0;
      end
      if (hs) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (ge) begin
        if (qa.size() == 0) begin
          qa.push_back(32'(m_c0));
          qa.push_back(32'(m_c1));
          qa.push_back(32'(m_cc));
          qb.push_back(sat4(m_c0));
          qb.push_back(sat4(m_c1));
          qb.push_back(sat4(m_cc));
`ifdef TEST_COINC_SEQUENCE_EN
          qa.push_back(m_seq);
          qb.push_back(m_seq);
`endif
        end else begin
          m_ovf = 1'b1;
        end
        m_c0 = 0; m_c1 = 0; m_cc = 0;
        m_seq = m_seq + 32'd1;
      end
    end
  end

  // Accepted words, for the directed packet checks
  logic [31:0] got_a[$];
  logic [31:0] got_b[$];
  logic        got_l[$];

  always @(negedge aclk) begin
    chk("tvalid_a", tvalid_a, 32'(qa.size() != 0));
    chk("tdata_a", tdata_a, (qa.size() != 0) ? qa[0] : 32'd0);
    chk("tlast_a", tlast_a, 32'(qa.size() == 1));
    chk("ovf_a", ovf_a, 32'(m_ovf));
    chk("tvalid_b", tvalid_b, 32'(qb.size() != 0));
    chk("tdata_b", tdata_b, (qb.size() != 0) ? qb[0] : 32'd0);
    chk("tlast_b", tlast_b, 32'(qb.size() == 1));
    chk("ovf_b", ovf_b, 32'(m_ovf));
    if (tvalid_a && tready) begin
      got_a.push_back(tdata_a);
      got_l.push_back(tlast_a);
    end
    if (tvalid_b && tready) got_b.push_back(tdata_b);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic clr_got();
    got_a.delete(); got_b.delete(); got_l.delete();
  endtask

  task automatic restart(input int cfg);
    run = 1'b0; test = 2'b00; tready = 1'b1;
    cyc(8);
    clr_got();
    cfg_gate = 32'(cfg);
    run = 1'b1;
  endtask

  task automatic pkt(input string nm, input int base,
                     input int w0, input int w1, input int w2);
    chk({nm, " w0"}, got_a[base],   32'(w0));
    chk({nm, " w1"}, got_a[base+1], 32'(w1));
    chk({nm, " w2"}, got_a[base+2], 32'(w2));
  endtask

  int n;

  initial begin
    aresetn = 1'b0; run = 1'b0; test = 2'b00;
    cfg_gate = 32'd10; tready = 1'b1;
    cyc(3);
    aresetn = 1'b1;
    cyc(2);
    chk("rst tvalid", tvalid_a, 0);
    chk("rst tdata", tdata_a, 0);
    chk("rst tlast", tlast_a, 0);
    chk("rst ovf", ovf_a, 0);

    // three ch0 pulses in one gate
    restart(10);
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      test = 2'b01; cyc(1); test = 2'b00; cyc(2);
    end
    cyc(20);
    pkt("t1", 0, 3, 0, 0);
    chk("t1 last0", got_l[0], 0);
    chk("t1 last1", got_l[1], 0);
    chk("t1 last2", got_l[2], 1);
    chk("t1 ovf", ovf_a, 0);

    // coincident pulses
    restart(10);
    cyc(1);
    test = 2'b11; cyc(1); test = 2'b00; cyc(1);
    test = 2'b11; cyc(1); test = 2'b00;
    cyc(20);
    pkt("t2", 0, 2, 2, 2);

    // level held across gates counts once
    restart(10);
    test = 2'b01;
    cyc(55);
    test = 2'b00;
    pkt("t3 p0", 0, 1, 0, 0);
    for (int p = 1; p < 5; p++) pkt("t3 pN", 3 * p, 0, 0, 0);

    // back-pressure: hold, drop, then drain
    restart(10);
    tready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j == 1) chk("t4 ovf early", ovf_a, 0);
      if (j == 2) begin
        chk("t4 ovf", ovf_a, 1);
        chk("t4 held valid", tvalid_a, 1);
        chk("t4 held data", tdata_a, 0);
      end
      cyc(2); test = 2'b10; cyc(1); test = 2'b00; cyc(7);
    end
    chk("t4 none yet", got_a.size(), 0);
    tready = 1'b1;
    cyc(2); test = 2'b10; cyc(1); test = 2'b00; cyc(3);
    chk("t4 one pkt", got_a.size(), 3);
    cyc(10);
    chk("t4 two pkt", got_a.size(), 6);
    pkt("t4 p0", 0, 0, 1, 0);
    pkt("t4 p1", 3, 0, 1, 0);

    // saturation in the 4-bit instance
    restart(64);
    cyc(1);
    for (int i = 0; i < 20; i++) begin
      test = 2'b01; cyc(1); test = 2'b00; cyc(2);
    end
    cyc(10);
    chk("t5 sat", got_b[0], 15);
    chk("t5 wide", got_a[0], 20);

    // reset in the middle of a packet
    restart(10);
    cyc(1);
    test = 2'b01; cyc(1); test = 2'b00;
    n = 0;
    while (!tvalid_a && n < 40) begin
      cyc(1); n++;
    end
    chk("t6 pkt seen", 32'(n < 40), 1);
    test = 2'b10;
    cyc(1);
    test = 2'b00; aresetn = 1'b0;
    cyc(1);
    chk("t6 valid drop", tvalid_a, 0);
    cyc(1);
    aresetn = 1'b1; test = 2'b01;
    clr_got();
    cyc(1);
    test = 2'b00;
    cyc(20);
    pkt("t6 post", 0, 1, 0, 0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      test    = 2'($urandom_range(0, 3));
      tready  = ($urandom_range(0, 3) != 0);
      run     = ($urandom_range(0, 63) != 0);
      aresetn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 39) == 0)
        cfg_gate = 32'($urandom_range(0, 12));
      cyc(1);
    end
    aresetn = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
